// File: rtl/datapath_sequencer.sv
// Multi-cycle controller for the register-file / ALU / 64x32 RAM datapath.
// Accepts one 20-bit instruction per pass through IDLE and sequences ISSUE, MEM, WB and DONE.
module datapath_sequencer #(
    parameter logic [2:0] ADD_OP = 3'b100
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [19:0] instr,
    input  logic        ZF,
    input  logic        OF,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [2:0]  ALU_OP,
    output logic        Write_Reg,
    output logic        Mem_Write,
    output logic [1:0]  wr_data_s,
    output logic        done,
    output logic        busy,
    output logic        zf_q,
    output logic        of_q
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_MEM, S_WB, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [19:0] r_instr, w_word;
    logic        w_accept, w_alu;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [2:0]  w_alu_op;
    logic        w_wreg, w_mwr, w_done;
    logic [1:0]  w_wsel;

    assign instr_ready = (r_state == S_IDLE) & Reset;
    assign w_accept    = instr_valid & instr_ready;
    // On the accept edge the outputs must already reflect the incoming word.
    assign w_word      = w_accept ? instr : r_instr;
    assign w_alu       = (w_word[19:18] == 2'b00);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ISSUE;
            S_ISSUE: w_next = (r_instr[19:18] == 2'b00) ? S_WB : S_MEM;
            S_MEM:   w_next = S_WB;
            S_WB:    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are computed from the state being entered.
    always_comb begin
        w_rs     = rs;
        w_rt     = rt;
        w_rd     = rd;
        w_alu_op = ALU_OP;
        w_wreg   = 1'b0;
        w_mwr    = 1'b0;
        w_wsel   = 2'b00;
        w_done   = 1'b0;
        case (w_next)
            S_IDLE: w_alu_op = ADD_OP;
            S_ISSUE, S_MEM, S_WB: begin
                w_rs     = w_word[14:10];
                w_rt     = w_word[9:5];
                w_rd     = w_word[4:0];
                w_alu_op = w_alu ? w_word[17:15] : ADD_OP;
                if (w_next == S_WB) begin
                    w_wreg = (w_word[19:18] != 2'b10);
                    w_mwr  = w_word[19];
                    w_wsel = w_alu ? 2'b00 : 2'b01;
                end
            end
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_instr   <= '0;
            rs        <= '0;
            rt        <= '0;
            rd        <= '0;
            ALU_OP    <= ADD_OP;
            Write_Reg <= 1'b0;
            Mem_Write <= 1'b0;
            wr_data_s <= 2'b00;
            done      <= 1'b0;
            busy      <= 1'b0;
            zf_q      <= 1'b0;
            of_q      <= 1'b0;
        end else begin
            r_state   <= w_next;
            if (w_accept) r_instr <= instr;
            rs        <= w_rs;
            rt        <= w_rt;
            rd        <= w_rd;
            ALU_OP    <= w_alu_op;
            Write_Reg <= w_wreg;
            Mem_Write <= w_mwr;
            wr_data_s <= w_wsel;
            done      <= w_done;
            busy      <= (w_next != S_IDLE);
            // Flags are captured on the write-back edge of ALU instructions only.
            if (r_state == S_WB && r_instr[19:18] == 2'b00) begin
                zf_q <= ZF;
                of_q <= OF;
            end
        end
    end
endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: behavioural datapath model plus an accept-time scoreboard
// that is popped and compared when the sequencer pulses done.
module tb_datapath_sequencer;
    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [19:0] instr = '0;
    logic        ZF, OF;
    logic [4:0]  rs, rt, rd;
    logic [2:0]  ALU_OP;
    logic        Write_Reg, Mem_Write, done, busy, zf_q, of_q;
    logic [1:0]  wr_data_s;

    datapath_sequencer #(.ADD_OP(3'b100)) dut (
        .clk(clk), .Reset(Reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .ZF(ZF), .OF(OF), .rs(rs), .rt(rt), .rd(rd), .ALU_OP(ALU_OP),
        .Write_Reg(Write_Reg), .Mem_Write(Mem_Write), .wr_data_s(wr_data_s),
        .done(done), .busy(busy), .zf_q(zf_q), .of_q(of_q)
    );

    always #5 clk = ~clk;

    // {ZF, OF, F}
    function automatic logic [33:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] f;
        logic        o;
        o = 1'b0;
        case (op)
            3'b000:  f = a & b;
            3'b001:  f = a | b;
            3'b101:  begin f = a - b; o = (a[31] != b[31]) && (f[31] != a[31]); end
            default: begin f = a + b; o = (a[31] == b[31]) && (f[31] != a[31]); end
        endcase
        return {(f == 32'd0), o, f};
    endfunction

    function automatic logic [19:0] mk(input logic [1:0] op, input logic [2:0] aop,
                                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {op, aop, s, t, d};
    endfunction

    // Datapath model: register file, synchronous-read RAM, combinational ALU
    logic [31:0] dp_reg [32];
    logic [31:0] dp_ram [64];
    logic [31:0] m_rdata, F;
    logic [33:0] w_alu;
    logic        pl_reg_we = 1'b0, pl_ram_we = 1'b0;
    logic [5:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    always_comb begin
        w_alu = alu(ALU_OP, dp_reg[rs], dp_reg[rt]);
        F  = w_alu[31:0];
        ZF = w_alu[33];
        OF = w_alu[32];
    end

    always @(posedge clk) begin
        m_rdata <= dp_ram[F[5:0]];
        if (Write_Reg) dp_reg[rd] <= (wr_data_s == 2'b01) ? m_rdata : F;
        if (Mem_Write) dp_ram[F[5:0]] <= dp_reg[rt];
        if (pl_reg_we) dp_reg[pl_addr[4:0]] <= pl_data;
        if (pl_ram_we) dp_ram[pl_addr] <= pl_data;
    end

    // Scoreboard
    typedef struct {
        logic [1:0]  op;
        logic [2:0]  aop;
        logic [4:0]  rs, rt, rd;
        int          acc;
        logic [5:0]  addr;
        logic [31:0] rval, mval;
        logic        zf, of;
    } ent_t;

    ent_t        sb[$];
    logic [31:0] ref_reg [32];
    logic [31:0] ref_ram [64];
    logic        ref_zf = 1'b0, ref_of = 1'b0;
    int          checks = 0, errors = 0;
    int          cyc = 0, acc_cnt = 0, done_cnt = 0, last_acc = 0, prev_acc = 0;

    task automatic mon_pos();
        ent_t        e;
        logic [33:0] r;
        logic [31:0] a, b, sum;
        forever begin
            @(posedge clk);
            if (instr_valid && instr_ready) begin
                e.op = instr[19:18]; e.aop = instr[17:15];
                e.rs = instr[14:10]; e.rt = instr[9:5]; e.rd = instr[4:0];
                e.acc = cyc;
                a = ref_reg[e.rs]; b = ref_reg[e.rt];
                sum = a + b;
                e.addr = sum[5:0];
                e.mval = b;
                if (e.op == 2'b00) begin
                    r = alu(e.aop, a, b);
                    e.rval = r[31:0]; e.zf = r[33]; e.of = r[32];
                end else begin
                    e.rval = ref_ram[e.addr]; e.zf = ref_zf; e.of = ref_of;
                end
                sb.push_back(e);
                prev_acc = last_acc; last_acc = cyc; acc_cnt++;
            end
            cyc++;
        end
    endtask

    task automatic mon_neg();
        ent_t e;
        int   k, lat;
        logic xwr, xmw, xbusy, xdone;
        logic [1:0] xws;
        forever begin
            @(negedge clk);
            if (Reset) begin
                {xwr, xmw, xws, xbusy, xdone} = '0;
                k = 0; lat = 0;
                if (sb.size() > 0) begin
                    e = sb[0];
                    k = cyc - e.acc;
                    lat = (e.op == 2'b00) ? 3 : 4;
                    xwr   = (k == lat - 1) && (e.op != 2'b10);
                    xmw   = (k == lat - 1) && e.op[1];
                    xws   = ((k == lat - 1) && (e.op != 2'b00)) ? 2'b01 : 2'b00;
                    xbusy = (k >= 1) && (k <= lat);
                    xdone = (k == lat);
                end
                checks++;
                if ({Write_Reg, Mem_Write, wr_data_s, busy, done} !== {xwr, xmw, xws, xbusy, xdone}) begin
                    errors++;
                    $display("FAIL ctl cyc=%0d k=%0d got wr/mw/ws/busy/done=%b%b%b%b%b exp %b%b%b%b%b",
                             cyc, k, Write_Reg, Mem_Write, wr_data_s, busy, done, xwr, xmw, xws, xbusy, xdone);
                end
                if (sb.size() > 0 && k >= 1 && k < lat) begin
                    checks++;
                    if ({rs, rt, rd, ALU_OP} !== {e.rs, e.rt, e.rd, (e.op == 2'b00) ? e.aop : 3'b100}) begin
                        errors++;
                        $display("FAIL drive k=%0d got rs/rt/rd/op=%0d/%0d/%0d/%b exp %0d/%0d/%0d", k, rs, rt, rd, ALU_OP, e.rs, e.rt, e.rd);
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        if (e.op != 2'b10) begin
                            checks++;
                            if (dp_reg[e.rd] !== e.rval) begin
                                errors++;
                                $display("FAIL reg_result REG[%0d] got %h exp %h", e.rd, dp_reg[e.rd], e.rval);
                            end
                            ref_reg[e.rd] = e.rval;
                        end
                        if (e.op[1]) begin
                            checks++;
                            if (dp_ram[e.addr] !== e.mval) begin
                                errors++;
                                $display("FAIL ram_result RAM[%0d] got %h exp %h", e.addr, dp_ram[e.addr], e.mval);
                            end
                            ref_ram[e.addr] = e.mval;
                        end
                        checks++;
                        if ({zf_q, of_q} !== {e.zf, e.of}) begin
                            errors++;
                            $display("FAIL flags got zf/of=%b%b exp %b%b", zf_q, of_q, e.zf, e.of);
                        end
                        ref_zf = e.zf; ref_of = e.of;
                    end
                end
            end
        end
    endtask

    task automatic preload(input bit is_ram, input logic [5:0] addr, input logic [31:0] data);
        @(negedge clk);
        pl_addr = addr; pl_data = data;
        pl_reg_we = !is_ram; pl_ram_we = is_ram;
        if (is_ram) ref_ram[addr] = data; else ref_reg[addr[4:0]] = data;
        @(negedge clk);
        pl_reg_we = 1'b0; pl_ram_we = 1'b0;
    endtask

    task automatic wait_acc(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = (acc_cnt >= target);
        end
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = (done_cnt >= target);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = (done_cnt >= target);
        end
    endtask

    task automatic send(input logic [19:0] w);
        bit ok;
        int a0, d0;
        a0 = acc_cnt; d0 = done_cnt;
        @(negedge clk);
        instr = w; instr_valid = 1'b1;
        wait_acc(a0 + 1, ok);
        instr_valid = 1'b0;
        instr = '0;
        checks++;
        if (!ok) begin errors++; $display("FAIL accept_timeout got %0d accepts exp %0d", acc_cnt, a0 + 1); end
        wait_done(d0 + 1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL done_timeout got %0d dones exp %0d", done_cnt, d0 + 1); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({rs, rt, rd, ALU_OP, Write_Reg, Mem_Write, wr_data_s, done, busy, zf_q, of_q, instr_ready}
            !== {15'd0, 3'b100, 9'd0}) begin
            errors++;
            $display("FAIL reset_values got rs%0d rt%0d rd%0d op%b wr%b mw%b ws%b d%b b%b z%b o%b rdy%b exp zeros/op100",
                     rs, rt, rd, ALU_OP, Write_Reg, Mem_Write, wr_data_s, done, busy, zf_q, of_q, instr_ready);
        end
        Reset = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b exp 1", instr_ready); end
    endtask

    task automatic test_alu_add();
        send(mk(2'b00, 3'b100, 5'd0, 5'd1, 5'd2));
        checks++;
        if ({dp_reg[2], zf_q, of_q} !== {32'hFFFF_FFFF, 2'b00}) begin
            errors++; $display("FAIL alu_add got %h z%b o%b exp ffffffff z0 o0", dp_reg[2], zf_q, of_q);
        end
        @(negedge clk);
        checks++;
        if ({rs, rt, rd, ALU_OP, busy} !== {5'd0, 5'd1, 5'd2, 3'b100, 1'b0}) begin
            errors++; $display("FAIL idle_hold got rs%0d rt%0d rd%0d op%b busy%b exp 0/1/2/100/0", rs, rt, rd, ALU_OP, busy);
        end
    endtask

    task automatic test_swap();
        send(mk(2'b11, 3'b010, 5'd0, 5'd1, 5'd3));
        checks++;
        if ({dp_reg[3], dp_ram[63]} !== {32'hAAAA_AAAA, 32'hFFFF_0000}) begin
            errors++; $display("FAIL swap got REG3 %h RAM63 %h exp aaaaaaaa ffff0000", dp_reg[3], dp_ram[63]);
        end
    endtask

    task automatic test_load_after_alu();
        send(mk(2'b00, 3'b101, 5'd0, 5'd0, 5'd5));
        checks++;
        if ({zf_q, of_q} !== 2'b10) begin errors++; $display("FAIL sub_flags got z%b o%b exp z1 o0", zf_q, of_q); end
        send(mk(2'b01, 3'b000, 5'd2, 5'd3, 5'd4));
        checks++;
        if ({dp_reg[4], zf_q, of_q} !== {32'h1234_5678, 2'b10}) begin
            errors++; $display("FAIL load got REG4 %h z%b o%b exp 12345678 z1 o0", dp_reg[4], zf_q, of_q);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int a0, d0;
        a0 = acc_cnt; d0 = done_cnt;
        @(negedge clk);
        instr = mk(2'b10, 3'b000, 5'd7, 5'd6, 5'd0); instr_valid = 1'b1;
        wait_acc(a0 + 1, ok);
        instr = mk(2'b00, 3'b100, 5'd6, 5'd7, 5'd8);
        wait_acc(a0 + 2, ok);
        instr_valid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_accept got %0d exp %0d", acc_cnt - a0, 2); end
        wait_done(d0 + 2, ok);
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", done_cnt - d0); end
        checks++;
        if (last_acc - prev_acc != 5) begin errors++; $display("FAIL b2b_gap got %0d exp 5", last_acc - prev_acc); end
        checks++;
        if ({dp_ram[0], dp_reg[8], zf_q, of_q} !== {32'h7FFF_FFFF, 32'h8000_0000, 2'b01}) begin
            errors++; $display("FAIL b2b_result got RAM0 %h REG8 %h z%b o%b exp 7fffffff 80000000 z0 o1", dp_ram[0], dp_reg[8], zf_q, of_q);
        end
    endtask

    task automatic test_reset_mid_store();
        bit ok;
        int a0, d0;
        logic seen_mw;
        a0 = acc_cnt;
        @(negedge clk);
        instr = mk(2'b10, 3'b000, 5'd7, 5'd1, 5'd0); instr_valid = 1'b1;
        wait_acc(a0 + 1, ok);
        instr_valid = 1'b0;
        @(negedge clk);
        Reset = 1'b0;
        sb.delete();
        d0 = done_cnt;
        seen_mw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen_mw |= Mem_Write | Write_Reg;
        end
        Reset = 1'b1;
        @(negedge clk);
        seen_mw |= Mem_Write | Write_Reg;
        checks++;
        if (instr_ready !== 1'b1 || of_q !== 1'b0) begin
            errors++; $display("FAIL mid_reset_ready got rdy%b of%b exp rdy1 of0", instr_ready, of_q);
        end
        repeat (4) begin
            @(negedge clk);
            seen_mw |= Mem_Write | Write_Reg;
        end
        checks++;
        if ({seen_mw, dp_ram[1], done_cnt - d0} !== {1'b0, 32'h5A5A_5A5A, 32'd0}) begin
            errors++; $display("FAIL mid_reset got we%b RAM1 %h dones %0d exp 0 5a5a5a5a 0", seen_mw, dp_ram[1], done_cnt - d0);
        end
        send(mk(2'b00, 3'b100, 5'd0, 5'd1, 5'd9));
        checks++;
        if (dp_reg[9] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL post_reset_alu got %h exp ffffffff", dp_reg[9]); end
    endtask

    initial begin
        fork
            mon_pos();
            mon_neg();
        join_none
        test_reset();
        preload(1'b0, 6'd0,  32'h0000_FFFF);
        preload(1'b0, 6'd1,  32'hFFFF_0000);
        preload(1'b0, 6'd6,  32'h7FFF_FFFF);
        preload(1'b0, 6'd7,  32'h0000_0001);
        preload(1'b1, 6'd63, 32'hAAAA_AAAA);
        preload(1'b1, 6'd41, 32'h1234_5678);
        preload(1'b1, 6'd1,  32'h5A5A_5A5A);
        test_alu_add();
        test_swap();
        test_load_after_alu();
        test_back_to_back();
        test_reset_mid_store();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Multi-cycle controller that sequences the register-file / ALU / 64x32 RAM datapath (`Comprehensive`). It accepts one instruction word at a time over a valid/ready handshake. It drives the datapath control inputs (`rs`, `rt`, `rd`, `ALU_OP`, `Write_Reg`, `Mem_Write`, `wr_data_s`) through issue, memory and write-back steps, and pulses `done` on completion. It also latches the ALU flags of the last ALU instruction.

## Interface
- `ADD_OP`, default 3'b100: ALU_OP code for addition; used for address generation and for the idle value.
- `clk`  in  1  clock; all state changes on rising edge.
- `Reset`  in  1  asynchronous, active-low reset (0 = reset).
- `instr_valid`  in  1  requester has an instruction on `instr`.
- `instr_ready`  out  1  sequencer can accept; equals (state==IDLE) & Reset.
- `instr`  in  20  [19:18] op, [17:15] alu_op, [14:10] rs, [9:5] rt, [4:0] rd.
- `ZF`, `OF`  in  1 each  flags from datapath ALU.
- `rs`, `rt`, `rd`  out  5 each  register addresses to datapath.
- `ALU_OP`  out  3  ALU operation select.
- `Write_Reg`  out  1  register-file write enable.
- `Mem_Write`  out  1  RAM write enable.
- `wr_data_s`  out  2  write-back select: 00 = ALU F, 01 = RAM M_R_Data.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in every state except IDLE.
- `zf_q`, `of_q`  out  1 each  flags latched from the last ALU op.

## Operation
- Opcodes:
  - 00 ALU: REG[rd] <= REG[rs] alu_op REG[rt].
  - 01 LOAD: REG[rd] <= RAM[(REG[rs]+REG[rt])[5:0]].
  - 10 STORE: RAM[addr] <= REG[rt].
  - 11 SWAP: REG[rd] <= RAM[addr] and RAM[addr] <= REG[rt] at the same edge.
- The instruction is accepted when `instr_valid & instr_ready` at a rising edge. The whole word is latched, so `instr` may change afterwards.
- States: IDLE, ISSUE, MEM, WB, DONE.
  - IDLE -> ISSUE on accept.
  - ISSUE -> WB for ALU ops; ISSUE -> MEM for LOAD, STORE and SWAP.
  - MEM -> WB.
  - WB -> DONE.
  - DONE -> IDLE.
- ISSUE:
  - `rs`, `rt`, `rd` are driven from the latched word.
  - `ALU_OP` = alu_op for ALU ops and `ADD_OP` for memory ops (the alu_op field is ignored).
  - Both write enables are 0.
- MEM: same drives as ISSUE. This cycle gives the synchronous RAM read time, so M_R_Data is valid during WB.
- WB: addresses and `ALU_OP` are unchanged from ISSUE.
  - `Write_Reg` = 1 for ALU, LOAD and SWAP.
  - `Mem_Write` = 1 for STORE and SWAP.
  - `wr_data_s` = 00 for ALU, 01 otherwise.
- SWAP: both writes commit at the WB/DONE edge. The register file receives the RAM value read before that edge (old content).
- `zf_q`/`of_q` load `ZF`/`OF` at the WB/DONE edge for ALU ops only. Memory ops leave them unchanged.
- DONE: `done` = 1, write enables 0, `wr_data_s` = 00.
- Outside WB: `Write_Reg` = 0, `Mem_Write` = 0, `wr_data_s` = 00.
- In IDLE: `ALU_OP` = `ADD_OP`, and `rs`/`rt`/`rd` hold their last values.
- rd = 0 is not special; register 0 is writable.
- Address wrap: only sum bits [5:0] reach the RAM (datapath behaviour). The sequencer performs no check.

## Timing
- Reset (Reset = 0), applied asynchronously:
  - State = IDLE.
  - `rs` = `rt` = `rd` = 0, `ALU_OP` = `ADD_OP`.
  - `Write_Reg` = `Mem_Write` = 0, `wr_data_s` = 00.
  - `done` = `busy` = 0, `zf_q` = `of_q` = 0, `instr_ready` = 0.
- All outputs except `instr_ready` are registered.
- Latency from accept edge (cycle 0) to `done` high:
  - ALU: cycle 3 (ISSUE 1, WB 2, DONE 3).
  - LOAD, STORE, SWAP: cycle 4.
- Throughput: the next accept can occur at the edge ending DONE+1 (IDLE cycle). `instr_ready` is low from ISSUE through DONE.
- Reset asserted mid-operation: write enables drop immediately, with no partial or late write at any following edge. The latched instruction is discarded, and `done` is not produced for it.
- `instr_valid` held high continuously: instructions are accepted one per pass through IDLE, in order. No instruction is dropped or duplicated.

## Test plan
- Reset check: hold Reset = 0 and toggle clk -> outputs equal the reset values above. Release Reset -> `instr_ready` = 1 in the next cycle.
- ALU add: preload REG[0] = 0000_FFFF, REG[1] = FFFF_0000; send op 00, alu_op 100, rs 0, rt 1, rd 2 -> `Write_Reg` high only in cycle 2, `wr_data_s` = 00, REG[2] = FFFF_FFFF, `done` in cycle 3, `zf_q` = 0, `of_q` = 0.
- SWAP: REG[0] = 0000_FFFF, REG[1] = FFFF_0000, RAM[63] = AAAA_AAAA; send op 11, rs 0, rt 1, rd 3 -> in cycle 3 `Write_Reg` = `Mem_Write` = 1 and `wr_data_s` = 01; then REG[3] = AAAA_AAAA, RAM[63] = FFFF_0000, `done` in cycle 4.
- LOAD after ALU: run the ALU add (flags latched), then LOAD rs 2, rt 3 (address (FFFF_FFFF + AAAA_AAAA)[5:0] = 41), rd 4 -> REG[4] = RAM[41]; `zf_q`/`of_q` unchanged by the LOAD.
- Back-to-back: keep `instr_valid` high with STORE then ALU -> second accept one cycle after the first `done`; exactly two `done` pulses; RAM and register contents correct.
- Reset mid-STORE: drive Reset low during MEM -> `Mem_Write` never goes high, RAM unchanged, no `done`; after release, `instr_ready` = 1 and the next instruction executes normally.
